axi_store_writer: RTL and testbench
===================================

// Module: axi_store_writer
// PURPOSE
//  AXI write-channel initiator for the memory stage: the write-direction counterpart of the load path's AR/R master.
//  Accepts one store (1/2/4/8 bytes) or one full cache-line writeback per request.
//  Drives AW/W/B and reports completion with a one-cycle done pulse plus an error flag.
//  Sits between the memory-stage handler / D-cache eviction logic and the AXI interconnect.
// PARAMETERS
//  LINE_BEATS  8  64-bit beats per cache line (power of 2, 2..16); LINE_BYTES = LINE_BEATS*8
// PORTS
//  clk          in   1    clock, all state on rising edge
//  reset        in   1    synchronous, active-high reset
//  req_valid    in   1    request valid
//  req_ready    out  1    high only in IDLE; request accepted on req_valid && req_ready
//  req_addr     in   64   byte address
//  req_data     in   64   store data, right-justified (single mode)
//  req_size     in   2    log2(bytes): 0=1B 1=2B 2=4B 3=8B (single mode)
//  req_line     in   1    1 = line writeback, 0 = single store
//  line_data    in   64*LINE_BEATS  line contents, beat i = bits [64*i+63 : 64*i]
//  done         out  1    one-cycle pulse when a request retires (success, bus error or misalign)
//  resp_err     out  1    valid with done: 1 = BRESP[1] set or misaligned request
//  m_axi_awvalid out 1  | m_axi_awready in 1 | m_axi_awaddr out 64 | m_axi_awlen out 8
//  m_axi_awsize out 3   | m_axi_awburst out 2
//  m_axi_wvalid out 1   | m_axi_wready in 1  | m_axi_wdata out 64 | m_axi_wstrb out 8 | m_axi_wlast out 1
//  m_axi_bvalid in 1    | m_axi_bready out 1 | m_axi_bresp in 2
// BEHAVIOUR
//  Reset: state IDLE; req_ready=1 after reset deasserts; done, resp_err, awvalid, wvalid, bready, wlast = 0; addr/data regs 0.
//  FSM: IDLE -> XFER (accept, aligned) | IDLE -> ERR (accept, misaligned); XFER -> RESP when AW and last W both handshaken;
//    RESP -> DONE on bvalid && bready; ERR -> IDLE; DONE -> IDLE.
//  Request latched into registers on acceptance; inputs ignored thereafter until IDLE.
//  Single: awaddr=req_addr, awlen=0, awsize=req_size, awburst=INCR(2'b01), wlast=1;
//    wdata = req_data << (8*addr[2:0]); wstrb = ((1<<(1<<size))-1) << addr[2:0].
//  Misaligned single (addr mod 2^size != 0): no AXI traffic; ERR state asserts done=1, resp_err=1 for one cycle.
//  Line: awaddr = req_addr & ~(LINE_BYTES-1), awlen=LINE_BEATS-1, awsize=3, INCR, wstrb=8'hFF,
//    beats sent in order 0..LINE_BEATS-1, wlast only on final beat; beat counter $clog2(LINE_BEATS) bits, no wrap.
//  XFER: awvalid and wvalid raised together in the first XFER cycle; each dropped independently after its handshake
//    (aw_done flag); W may complete before, with or after AW. Payload stable while valid && !ready.
//  RESP: bready=1 only in RESP; bvalid outside RESP is ignored (never early-acknowledged).
//  DONE: done=1 for exactly one cycle; resp_err = captured bresp[1] (SLVERR/DECERR = 1, OKAY/EXOKAY = 0).
//  Latency, zero-wait bus: accept cycle 0, AW+W handshake cycle 1, bvalid cycle 2, done cycle 3.
//    Line adds LINE_BEATS-1 cycles. req_ready returns high the cycle after done.
//  Reset mid-transaction: all valids drop next edge, FSM to IDLE, no done pulse; the interconnect resets with it.
// STRUCTURE
//  Shared package: axi_burst_t constants (FIXED/INCR/WRAP), axi_resp_t codes, store_req_struct typedef
//    (addr, data, size, line), LINE_BEATS default.
//  Sub-module: store_lane_align (combinational) computes wdata shift, wstrb and misalign flag from addr[2:0]/size.
//  Top holds the FSM, request registers, beat counter and aw_done flag.
// TESTING
//  T1 single 8B: addr 0x1000, data 0xDEADBEEF_CAFEF00D, zero-wait -> awaddr 0x1000, awlen 0, awsize 3,
//     wstrb 0xFF, wlast 1, done at cycle 3, resp_err 0.
//  T2 single 2B: addr 0x1006, data 0xABCD -> wdata 0xABCD0000_00000000, wstrb 0xC0, awsize 1.
//  T3 misaligned: addr 0x1003, size 2 -> no awvalid/wvalid ever, done=1, resp_err=1 cycle after accept.
//  T4 line: addr 0x2038, LINE_BEATS 8, wready toggled 1-0-1 -> awaddr 0x2000, awlen 7, 8 beats in order,
//     wlast only on beat 7, data held during stalls.
//  T5 ordering: awready delayed 5 cycles after W done, bvalid asserted early with bresp 2'b10 -> bready only in RESP,
//     done with resp_err=1.
//  T6 reset at beat 3 of a line -> next cycle all valids 0, req_ready 1, no done; a new single store then completes.

Source files
------------

// File: rtl/axi_store_writer_pkg.sv
// Shared types for the memory-stage AXI store writer: burst/response codes,
// the latched store request and the writer FSM states.
package axi_store_writer_pkg;

  localparam int LINE_BEATS_DEFAULT = 8;
  localparam logic [2:0] BEAT_SIZE_8B = 3'd3;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'b00,
    AXI_BURST_INCR  = 2'b01,
    AXI_BURST_WRAP  = 2'b10
  } axi_burst_t;

  typedef enum logic [1:0] {
    AXI_RESP_OKAY   = 2'b00,
    AXI_RESP_EXOKAY = 2'b01,
    AXI_RESP_SLVERR = 2'b10,
    AXI_RESP_DECERR = 2'b11
  } axi_resp_t;

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] data;
    logic [1:0]  size;
    logic        line;
  } store_req_struct;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_XFER,
    ST_RESP,
    ST_DONE,
    ST_ERR
  } writer_state_t;

  // SLVERR and DECERR both carry bit 1; OKAY/EXOKAY are successes.
  function automatic logic resp_is_error(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/axi_store_writer_align.sv
// Byte-lane placement for a single store: shifts right-justified data onto
// its lanes, builds the write strobe and flags natural-alignment violations.
module store_lane_align
  import axi_store_writer_pkg::*;
(
  input  logic [2:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic [63:0] data,
  output logic [63:0] wdata,
  output logic [7:0]  wstrb,
  output logic        misalign
);

  logic [7:0] base_strb;
  logic [2:0] align_mask;

  // NOTE: every signal written here gets a value on every path (defaults first), so no latch is inferred.
  always_comb begin
    base_strb  = 8'h01;
    align_mask = 3'b000;
    unique case (size)
      2'd0: begin base_strb = 8'h01; align_mask = 3'b000; end
      2'd1: begin base_strb = 8'h03; align_mask = 3'b001; end
      2'd2: begin base_strb = 8'h0F; align_mask = 3'b011; end
      2'd3: begin base_strb = 8'hFF; align_mask = 3'b111; end
      default: ;
    endcase
    misalign = |(addr_lo & align_mask);
    wstrb    = base_strb << addr_lo;
    wdata    = data << {addr_lo, 3'b000};
  end

endmodule

// File: rtl/axi_store_writer.sv
// AXI AW/W/B initiator for single stores and cache-line writebacks; retires
// each request with a one-cycle done pulse and an error flag.
module axi_store_writer
  import axi_store_writer_pkg::*;
#(
  parameter int LINE_BEATS = LINE_BEATS_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [63:0]             req_addr,
  input  logic [63:0]             req_data,
  input  logic [1:0]              req_size,
  input  logic                    req_line,
  input  logic [64*LINE_BEATS-1:0] line_data,
  output logic                    done,
  output logic                    resp_err,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [63:0]             m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  output logic [63:0]             m_axi_wdata,
  output logic [7:0]              m_axi_wstrb,
  output logic                    m_axi_wlast,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  input  logic [1:0]              m_axi_bresp
);

  localparam int LINE_BYTES = LINE_BEATS * 8;
  localparam int BEAT_W     = $clog2(LINE_BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);
  localparam logic [63:0] LINE_MASK = ~64'(LINE_BYTES - 1);

  writer_state_t           state, state_next;
  store_req_struct         req_q;
  logic [64*LINE_BEATS-1:0] line_q;
  logic [BEAT_W-1:0]       beat_q;
  logic                    aw_done_q, w_done_q, bresp_err_q;

  logic [2:0]  align_addr_lo;
  logic [1:0]  align_size;
  logic [63:0] single_wdata;
  logic [7:0]  single_wstrb;
  logic        misalign;
  logic        last_beat, aw_fire, w_fire;

  // In IDLE the aligner looks at the incoming request (misalign decision);
  // afterwards it formats the latched store.
  assign align_addr_lo = (state == ST_IDLE) ? req_addr[2:0] : req_q.addr[2:0];
  assign align_size    = (state == ST_IDLE) ? req_size      : req_q.size;

  store_lane_align u_align (
    .addr_lo  (align_addr_lo),
    .size     (align_size),
    .data     (req_q.data),
    .wdata    (single_wdata),
    .wstrb    (single_wstrb),
    .misalign (misalign)
  );

  assign last_beat = !req_q.line || (beat_q == LAST_BEAT);
  assign aw_fire   = (state == ST_XFER) && !aw_done_q && m_axi_awready;
  assign w_fire    = (state == ST_XFER) && !w_done_q && m_axi_wready;

  assign m_axi_awaddr  = req_q.line ? (req_q.addr & LINE_MASK) : req_q.addr;
  assign m_axi_awlen   = req_q.line ? 8'(LINE_BEATS - 1) : 8'd0;
  assign m_axi_awsize  = req_q.line ? BEAT_SIZE_8B : {1'b0, req_q.size};
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_wdata   = req_q.line ? line_q[64*beat_q +: 64] : single_wdata;
  assign m_axi_wstrb   = req_q.line ? 8'hFF : single_wstrb;
  assign m_axi_wlast   = (state == ST_XFER) && last_beat;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = state;
    req_ready     = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    done          = 1'b0;
    resp_err      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = (misalign && !req_line) ? ST_ERR : ST_XFER;
      end
      ST_XFER: begin
        m_axi_awvalid = !aw_done_q;
        m_axi_wvalid  = !w_done_q;
        if ((aw_done_q || aw_fire) && (w_done_q || (w_fire && last_beat)))
          state_next = ST_RESP;
      end
      ST_RESP: begin
        // B is only acknowledged here, so an early bvalid just waits.
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) state_next = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        resp_err   = bresp_err_q;
        state_next = ST_IDLE;
      end
      ST_ERR: begin
        done       = 1'b1;
        resp_err   = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the request/line registers are plain flops, not a RAM, so clearing them on reset is cheap and keeps outputs defined.
      req_q       <= '0;
      line_q      <= '0;
      beat_q      <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      bresp_err_q <= 1'b0;
    end else begin
      if (state == ST_IDLE && req_valid) begin
        req_q     <= '{addr: req_addr, data: req_data, size: req_size, line: req_line};
        line_q    <= line_data;
        beat_q    <= '0;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end
      if (aw_fire) aw_done_q <= 1'b1;
      if (w_fire) begin
        if (last_beat) w_done_q <= 1'b1;
        else           beat_q   <= beat_q + 1'b1;
      end
      if (state == ST_RESP && m_axi_bvalid) bresp_err_q <= resp_is_error(m_axi_bresp);
    end
  end

endmodule

// File: tb/tb_axi_store_writer.sv
// Self-checking bench for axi_store_writer: table of single/line requests plus
// hand-written stall, ordering and reset sequences, checked by AW/W/done scoreboards.
module tb_axi_store_writer;
  import axi_store_writer_pkg::*;

  localparam int LB = 8;

  logic clk = 1'b0;
  logic reset;
  logic req_valid, req_ready, req_line;
  logic [63:0] req_addr, req_data;
  logic [1:0] req_size;
  logic [64*LB-1:0] line_data;
  logic done, resp_err;
  logic awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [63:0] awaddr, wdata;
  logic [7:0] awlen, wstrb;
  logic [2:0] awsize;
  logic [1:0] awburst, bresp;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  axi_store_writer #(.LINE_BEATS(LB)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_data(req_data),
    .req_size(req_size), .req_line(req_line), .line_data(line_data),
    .done(done), .resp_err(resp_err),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen),
    .m_axi_awsize(awsize), .m_axi_awburst(awburst),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
    .m_axi_wlast(wlast),
    .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bresp(bresp)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: event occurred with nothing expected", name);
  endtask

  // Scoreboards
  typedef struct { logic [63:0] addr; logic [7:0] len; logic [2:0] size; } aw_exp_t;
  typedef struct { logic [63:0] data; logic [7:0] strb; logic last; } w_exp_t;
  aw_exp_t aw_q[$];
  w_exp_t  w_q[$];
  logic    d_q[$];
  aw_exp_t ae;
  w_exp_t  we;

  // B-channel slave: automatic (respond after AW and last W) or manually driven.
  logic auto_b, bvalid_auto, bvalid_man, aw_seen, w_seen;
  logic [1:0] bresp_cfg, bresp_man;
  assign bvalid = auto_b ? bvalid_auto : bvalid_man;
  assign bresp  = auto_b ? bresp_cfg : bresp_man;

  always @(posedge clk) begin
    if (reset || !auto_b) begin
      aw_seen <= 1'b0; w_seen <= 1'b0; bvalid_auto <= 1'b0;
    end else if (bvalid_auto && bready) begin
      aw_seen <= 1'b0; w_seen <= 1'b0; bvalid_auto <= 1'b0;
    end else begin
      if (awvalid && awready) aw_seen <= 1'b1;
      if (wvalid && wready && wlast) w_seen <= 1'b1;
      if ((aw_seen || (awvalid && awready)) && (w_seen || (wvalid && wready && wlast)))
        bvalid_auto <= 1'b1;
    end
  end

  // Monitors, sampled on the falling edge.
  logic aw_stall, w_stall;
  logic [63:0] aw_prev_addr, w_prev_data;
  always @(negedge clk) begin
    if (reset) begin
      aw_stall <= 1'b0;
      w_stall  <= 1'b0;
    end else begin
      if (aw_stall) begin
        check("aw_hold_valid", awvalid, 1);
        check("aw_hold_addr", awaddr, aw_prev_addr);
      end
      if (w_stall) begin
        check("w_hold_valid", wvalid, 1);
        check("w_hold_data", wdata, w_prev_data);
      end
      aw_stall     <= awvalid && !awready;
      w_stall      <= wvalid && !wready;
      aw_prev_addr <= awaddr;
      w_prev_data  <= wdata;
      if (awvalid && awready) begin
        if (aw_q.size() == 0) fail("aw_unexpected");
        else begin
          ae = aw_q.pop_front();
          check("awaddr", awaddr, ae.addr);
          check("awlen", awlen, ae.len);
          check("awsize", awsize, ae.size);
          check("awburst", awburst, 2'b01);
        end
      end
      if (wvalid && wready) begin
        if (w_q.size() == 0) fail("w_unexpected");
        else begin
          we = w_q.pop_front();
          check("wdata", wdata, we.data);
          check("wstrb", wstrb, we.strb);
          check("wlast", wlast, we.last);
        end
      end
      if (bvalid && (awvalid || wvalid)) check("bready_early", bready, 0);
      if (done) begin
        if (d_q.size() == 0) fail("done_unexpected");
        else check("resp_err", resp_err, d_q.pop_front());
      end
    end
  end

  function automatic logic [63:0] beat_pat(input int seed, input int i);
    return {32'hC0DE0000 + 32'(seed), 32'hBEEF0000 + 32'(i)};
  endfunction

  function automatic logic [64*LB-1:0] line_pat(input int seed);
    logic [64*LB-1:0] v;
    for (int i = 0; i < LB; i++) v[64*i +: 64] = beat_pat(seed, i);
    return v;
  endfunction

  task automatic push_line(input logic [63:0] a, input int seed);
    aw_q.push_back('{addr: a, len: 8'(LB-1), size: 3'd3});
    for (int i = 0; i < LB; i++)
      w_q.push_back('{data: beat_pat(seed, i), strb: 8'hFF, last: (i == LB-1)});
  endtask

  // Entered and left just after a rising edge; accepts on the next edge.
  task automatic do_req(input logic [63:0] a, input logic [63:0] d, input logic [1:0] s,
                        input logic l, input logic [64*LB-1:0] ld);
    req_valid = 1'b1; req_addr = a; req_data = d; req_size = s; req_line = l; line_data = ld;
    @(negedge clk);
    check("req_ready_idle", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = {$urandom, $urandom};
    req_data  = {$urandom, $urandom};
    req_size  = 2'($urandom);
    req_line  = 1'($urandom);
    for (int i = 0; i < 2*LB; i++) line_data[32*i +: 32] = $urandom;
  endtask

  // mode 0: ready held; 1: wready toggles 1-0-1; 2: awready low until cycle 7.
  task automatic run_to_done(input int mode, output int lat);
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      if (mode == 1) wready = k[0];
      if (mode == 2) awready = (k >= 7);
      @(negedge clk);
      if (done) begin
        lat = k;
        check("req_ready_in_done", req_ready, 0);
        break;
      end
      @(posedge clk); #1;
    end
    if (lat < 0) begin
      fail("done_timeout");
    end else begin
      @(posedge clk); #1;
      @(negedge clk);
      check("req_ready_after_done", req_ready, 1);
      check("done_one_cycle", done, 0);
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    string       name;
    logic [63:0] addr;
    logic [63:0] data;
    logic [1:0]  size;
    logic        line;
    logic [1:0]  bresp;
    logic        traffic;
    logic [63:0] exp_awaddr;
    logic [2:0]  exp_awsize;
    logic [63:0] exp_wdata;
    logic [7:0]  exp_wstrb;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[9];
  int lat;

  initial begin
    vecs[0] = '{"t1_single_8b", 64'h1000, 64'hDEADBEEF_CAFEF00D, 2'd3, 1'b0, 2'b00, 1'b1,
                64'h1000, 3'd3, 64'hDEADBEEF_CAFEF00D, 8'hFF, 1'b0, 3};
    vecs[1] = '{"t2_single_2b", 64'h1006, 64'hABCD, 2'd1, 1'b0, 2'b00, 1'b1,
                64'h1006, 3'd1, 64'hABCD0000_00000000, 8'hC0, 1'b0, 3};
    vecs[2] = '{"single_1b", 64'h2001, 64'h5A, 2'd0, 1'b0, 2'b00, 1'b1,
                64'h2001, 3'd0, 64'h5A00, 8'h02, 1'b0, 3};
    vecs[3] = '{"single_4b_slverr", 64'h3004, 64'h11223344, 2'd2, 1'b0, 2'b10, 1'b1,
                64'h3004, 3'd2, 64'h11223344_00000000, 8'hF0, 1'b1, 3};
    vecs[4] = '{"t3_misalign_4b", 64'h1003, 64'h55, 2'd2, 1'b0, 2'b00, 1'b0,
                64'h0, 3'd0, 64'h0, 8'h00, 1'b1, 1};
    vecs[5] = '{"misalign_8b", 64'h100A, 64'h66, 2'd3, 1'b0, 2'b00, 1'b0,
                64'h0, 3'd0, 64'h0, 8'h00, 1'b1, 1};
    vecs[6] = '{"single_1b_decerr", 64'h4007, 64'hFF, 2'd0, 1'b0, 2'b11, 1'b1,
                64'h4007, 3'd0, 64'hFF000000_00000000, 8'h80, 1'b1, 3};
    vecs[7] = '{"single_2b_exokay", 64'h5002, 64'h1234, 2'd1, 1'b0, 2'b01, 1'b1,
                64'h5002, 3'd1, 64'h12340000, 8'h0C, 1'b0, 3};
    vecs[8] = '{"line_zero_wait", 64'h707C, 64'h0, 2'd3, 1'b1, 2'b00, 1'b1,
                64'h7040, 3'd3, 64'h0, 8'hFF, 1'b0, 10};

    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = '0;
    req_line = 1'b0; line_data = '0; awready = 1'b1; wready = 1'b1;
    auto_b = 1'b1; bvalid_man = 1'b0; bresp_cfg = 2'b00; bresp_man = 2'b00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_done", done, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_bready", bready, 0);
    check("rst_wlast", wlast, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      bresp_cfg = vecs[i].bresp;
      if (vecs[i].traffic) begin
        if (vecs[i].line) push_line(vecs[i].exp_awaddr, i);
        else begin
          aw_q.push_back('{addr: vecs[i].exp_awaddr, len: 8'd0, size: vecs[i].exp_awsize});
          w_q.push_back('{data: vecs[i].exp_wdata, strb: vecs[i].exp_wstrb, last: 1'b1});
        end
      end
      d_q.push_back(vecs[i].exp_err);
      do_req(vecs[i].addr, vecs[i].data, vecs[i].size, vecs[i].line, line_pat(i));
      run_to_done(0, lat);
      check({vecs[i].name, "_latency"}, 64'(lat), 64'(vecs[i].exp_lat));
    end

    // T4: line with wready toggling; beats held across stalls.
    bresp_cfg = 2'b00;
    push_line(64'h2000, 4);
    d_q.push_back(1'b0);
    do_req(64'h2038, 64'h0, 2'd0, 1'b1, line_pat(4));
    run_to_done(1, lat);
    check("t4_latency", 64'(lat), 64'd17);
    wready = 1'b1;

    // T5: W first, AW late, bvalid (SLVERR) raised early and held.
    aw_q.push_back('{addr: 64'h6000, len: 8'd0, size: 3'd3});
    w_q.push_back('{data: 64'h01234567_89ABCDEF, strb: 8'hFF, last: 1'b1});
    d_q.push_back(1'b1);
    auto_b = 1'b0;
    do_req(64'h6000, 64'h01234567_89ABCDEF, 2'd3, 1'b0, '0);
    bvalid_man = 1'b1; bresp_man = 2'b10;
    run_to_done(2, lat);
    check("t5_latency", 64'(lat), 64'd9);
    bvalid_man = 1'b0; bresp_man = 2'b00; auto_b = 1'b1; awready = 1'b1;

    // T6: reset while beat 3 of a line is on the bus.
    push_line(64'h9000, 20);
    do_req(64'h9000, 64'h0, 2'd3, 1'b1, line_pat(20));
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("t6_no_done_pre", done, 0);
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(negedge clk);
    check("t6_no_done_beat3", done, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t6_awvalid", awvalid, 0);
    check("t6_wvalid", wvalid, 0);
    check("t6_bready", bready, 0);
    check("t6_req_ready", req_ready, 1);
    check("t6_done", done, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    aw_q.delete(); w_q.delete(); d_q.delete();
    aw_q.push_back('{addr: 64'hA010, len: 8'd0, size: 3'd3});
    w_q.push_back('{data: 64'h0F1E2D3C_4B5A6978, strb: 8'hFF, last: 1'b1});
    d_q.push_back(1'b0);
    do_req(64'hA010, 64'h0F1E2D3C_4B5A6978, 2'd3, 1'b0, '0);
    run_to_done(0, lat);
    check("t6_after_latency", 64'(lat), 64'd3);

    check("aw_q_drained", 64'(aw_q.size()), 64'd0);
    check("w_q_drained", 64'(w_q.size()), 64'd0);
    check("d_q_drained", 64'(d_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
